note_recorder: RTL and testbench

Beat-synchronous note recorder: the writer that fills the 64-beat note memory the playback path later reads by `ibeat`. On each beat tick while recording, it samples the live keyboard note code and stores it at the current write beat. It then advances, wraps and reports the take length. It exposes a registered read port addressed by the player's beat index, so the recorder and `player_control` form the two ends of one beat-addressed note store.

---
 rtl/music_pkg.sv | 27 ++
 rtl/note_recorder_if.sv | 30 +++
 rtl/note_ram.sv | 43 ++++
 rtl/note_recorder.sv | 113 +++++++++++
 tb/tb_note_recorder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared constants and types for the beat-addressed note store.
// The recorder, player_control and the note decoders all use these values.
package music_pkg;

    // Beats per take (memory depth).
    localparam int LEN    = 64;
    // Beat address width, log2(LEN).
    localparam int ADDR_W = 6;
    // Note code width; code 0 is a rest.
    localparam int NOTE_W = 5;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    // Recorder state encodings, also exported on the state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_REC   = 2'd2,
        ST_DONE  = 2'd3
    } rec_state_t;

    // True when the code carries an actual note rather than a rest.
    function automatic logic is_note(input logic [NOTE_W-1:0] code);
        return code != NOTE_REST;
    endfunction

endpackage

// File: rtl/note_recorder_if.sv
// Control and data bundle between the recorder and its driving logic
// (beat divider, keyboard decoder, playback index).
interface note_recorder_if;
    import music_pkg::*;

    logic              beat_en;
    logic              rec_start;
    logic              rec_stop;
    logic              overdub;
    logic [NOTE_W-1:0] note_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [NOTE_W-1:0] rd_note;
    logic [ADDR_W-1:0] wr_ibeat;
    logic [ADDR_W:0]   rec_len;
    logic              full;
    logic [1:0]        state;

    // Side that drives beats, commands and the playback index.
    modport master (
        output beat_en, rec_start, rec_stop, overdub, note_in, rd_addr,
        input  rd_note, wr_ibeat, rec_len, full, state
    );

    // The recorder itself.
    modport slave (
        input  beat_en, rec_start, rec_stop, overdub, note_in, rd_addr,
        output rd_note, wr_ibeat, rec_len, full, state
    );

endinterface

// File: rtl/note_ram.sv
// LEN x NOTE_W note memory: one write port, one registered read port,
// whole array cleared by the asynchronous active-low reset.
// A same-edge read and write to one address returns the old contents.
module note_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Register array: cleared on reset, single write port otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read, sampling the array before this edge's write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/note_recorder.sv
// Beat-synchronous note recorder. Samples the live note on each beat
// while recording, stores it at the current write beat, advances and
// wraps the write address and reports the take length. Playback reads
// the same store through the registered rd_addr/rd_note port.
module note_recorder
    import music_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    note_recorder_if.slave bus
);

    rec_state_t        r_state;
    logic [ADDR_W-1:0] r_wr_ibeat;
    logic [ADDR_W:0]   r_rec_len;
    logic              r_full;

    logic              w_arm_beat;
    logic              w_rec_beat;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [NOTE_W-1:0] w_rd_note;

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LEN - 1);

    // First beat of a take: a simultaneous stop cancels it before any write.
    assign w_arm_beat = (r_state == ST_ARMED) && bus.beat_en && !bus.rec_stop;
    // Beat inside a take: a simultaneous stop still lets this beat land.
    assign w_rec_beat = (r_state == ST_REC) && bus.beat_en;

    // In overdub mode rests leave the stored note alone; counters still move.
    assign w_we    = (w_arm_beat || w_rec_beat) &&
                     (!bus.overdub || is_note(bus.note_in));
    assign w_waddr = w_arm_beat ? '0 : r_wr_ibeat;

    note_ram #(
        .DEPTH (LEN),
        .AW    (ADDR_W),
        .DW    (NOTE_W)
    ) u_note_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (bus.note_in),
        .raddr (bus.rd_addr),
        .rdata (w_rd_note)
    );

    // Take control FSM with its write address, length and full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wr_ibeat <= '0;
            r_rec_len  <= '0;
            r_full     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rec_start) begin
                        r_state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (bus.rec_stop) begin
                        r_state <= ST_IDLE;
                    end else if (bus.beat_en) begin
                        // Beat-aligned start: address 0 is written this edge.
                        r_wr_ibeat <= ADDR_W'(1);
                        r_rec_len  <= (ADDR_W+1)'(1);
                        r_full     <= 1'b0;
                        r_state    <= ST_REC;
                    end
                end

                ST_REC: begin
                    if (bus.beat_en) begin
                        r_wr_ibeat <= r_wr_ibeat + 1'b1;
                        if (r_rec_len != LEN_MAX) begin
                            r_rec_len <= r_rec_len + 1'b1;
                        end
                        if (r_wr_ibeat == LAST_IDX) begin
                            r_full <= 1'b1;
                        end
                    end
                    if (bus.rec_stop || (bus.beat_en && r_wr_ibeat == LAST_IDX)) begin
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Length and full flag stay until the next take's first write.
                    if (bus.rec_start) begin
                        r_state <= ST_ARMED;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state    = r_state;
    assign bus.wr_ibeat = r_wr_ibeat;
    assign bus.rec_len  = r_rec_len;
    assign bus.full     = r_full;
    assign bus.rd_note  = w_rd_note;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: takes, overdub, stop/beat collisions,
// full take wrap and reset during recording, with hand-computed results.
module tb_note_recorder;

    logic clk;
    logic rst;

    note_recorder_if bus ();

    note_recorder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.rec_start = 1'b1;
        @(negedge clk);
        bus.rec_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        bus.rec_stop = 1'b1;
        @(negedge clk);
        bus.rec_stop = 1'b0;
    endtask

    task automatic beat(input logic [4:0] note, input logic stop);
        @(negedge clk);
        bus.beat_en  = 1'b1;
        bus.note_in  = note;
        bus.rec_stop = stop;
        @(negedge clk);
        bus.beat_en  = 1'b0;
        bus.rec_stop = 1'b0;
        bus.note_in  = 5'd0;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] addr, input int exp);
        @(negedge clk);
        bus.rd_addr = addr;
        @(negedge clk);
        chk(tag, 32'(bus.rd_note), exp);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.beat_en = 0; bus.rec_start = 0; bus.rec_stop = 0;
        bus.overdub = 0; bus.note_in = '0; bus.rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Preload memory, then reset must clear everything.
        pulse_start();
        beat(5'd3, 1'b0); beat(5'd4, 1'b0); beat(5'd6, 1'b0);
        pulse_stop();
        rd_check("preload_a1", 6'd1, 4);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_len", 32'(bus.rec_len), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_wr", 32'(bus.wr_ibeat), 0);
        rd_check("rst_rd0", 6'd0, 0);
        rd_check("rst_rd1", 6'd1, 0);
        rd_check("rst_rd2", 6'd2, 0);

        // Beat while idle does nothing.
        beat(5'd9, 1'b0);
        chk("idle_beat_state", 32'(bus.state), 0);
        chk("idle_beat_wr", 32'(bus.wr_ibeat), 0);

        // Basic take: 5, 0, 9.
        pulse_start();
        chk("armed", 32'(bus.state), 1);
        beat(5'd5, 1'b0);
        chk("first_wr", 32'(bus.wr_ibeat), 1);
        chk("first_len", 32'(bus.rec_len), 1);
        chk("rec_state", 32'(bus.state), 2);
        beat(5'd0, 1'b0); beat(5'd9, 1'b0);
        pulse_stop();
        chk("take_len", 32'(bus.rec_len), 3);
        chk("take_done", 32'(bus.state), 3);
        chk("take_full", 32'(bus.full), 0);
        rd_check("take_rd0", 6'd0, 5);
        rd_check("take_rd1", 6'd1, 0);
        rd_check("take_rd2", 6'd2, 9);

        // Overdub take: rests keep old notes.
        bus.overdub = 1'b1;
        pulse_start();
        beat(5'd0, 1'b0); beat(5'd7, 1'b0); beat(5'd0, 1'b0);
        pulse_stop();
        bus.overdub = 1'b0;
        chk("od_len", 32'(bus.rec_len), 3);
        rd_check("od_rd0", 6'd0, 5);
        rd_check("od_rd1", 6'd1, 7);
        rd_check("od_rd2", 6'd2, 9);

        // Stop and beat together while armed: stop wins, nothing written.
        pulse_start();
        beat(5'd20, 1'b1);
        chk("armed_stop_state", 32'(bus.state), 0);
        chk("armed_stop_len", 32'(bus.rec_len), 3);
        rd_check("armed_stop_rd0", 6'd0, 5);

        // Stop and beat together in REC at wr_ibeat=4: beat lands first.
        pulse_start();
        beat(5'd1, 1'b0); beat(5'd2, 1'b0); beat(5'd3, 1'b0); beat(5'd4, 1'b0);
        chk("pre_stop_wr", 32'(bus.wr_ibeat), 4);
        beat(5'd11, 1'b1);
        chk("rec_stop_len", 32'(bus.rec_len), 5);
        chk("rec_stop_state", 32'(bus.state), 3);
        chk("rec_stop_wr", 32'(bus.wr_ibeat), 5);
        rd_check("rec_stop_rd4", 6'd4, 11);

        // Full 64-beat take, with read-before-write on address 0.
        pulse_start();
        bus.rd_addr = 6'd0;
        for (int i = 0; i < 64; i++) begin
            beat(5'((i % 29) + 2), 1'b0);
            if (i == 0) chk("rbw_old", 32'(bus.rd_note), 1);
            if (i == 1) chk("rbw_new", 32'(bus.rd_note), 2);
            if (i == 62) chk("pre_full", 32'(bus.full), 0);
        end
        chk("full_flag", 32'(bus.full), 1);
        chk("full_len", 32'(bus.rec_len), 64);
        chk("full_wr", 32'(bus.wr_ibeat), 0);
        chk("full_state", 32'(bus.state), 3);
        beat(5'd30, 1'b0);
        chk("beat65_len", 32'(bus.rec_len), 64);
        chk("beat65_wr", 32'(bus.wr_ibeat), 0);
        rd_check("full_rd0", 6'd0, 2);
        rd_check("full_rd28", 6'd28, 30);
        rd_check("full_rd63", 6'd63, 7);

        // Reset in the middle of a take at wr_ibeat=10.
        pulse_start();
        for (int i = 0; i < 10; i++) beat(5'd7, 1'b0);
        chk("mid_wr", 32'(bus.wr_ibeat), 10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_state", 32'(bus.state), 0);
        chk("mid_rst_wr", 32'(bus.wr_ibeat), 0);
        chk("mid_rst_len", 32'(bus.rec_len), 0);
        chk("mid_rst_full", 32'(bus.full), 0);
        chk("mid_rst_rd", 32'(bus.rd_note), 0);
        @(negedge clk);
        rst = 1'b1;
        rd_check("mid_rst_rd5", 6'd5, 0);
        pulse_start();
        beat(5'd13, 1'b0);
        chk("after_rst_len", 32'(bus.rec_len), 1);
        rd_check("after_rst_rd0", 6'd0, 13);
        rd_check("after_rst_rd1", 6'd1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
